// File: rtl/mram_pkg.sv
// Shared types and constants for the MRAM access arbiter.
package mram_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    // {chip_en, write_en, out_en, lower_byte_en, upper_byte_en}, all deasserted
    localparam logic [4:0] STROBES_IDLE = 5'b11111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_DONE
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mram_rr_arb.sv
// Two-way round-robin arbiter. On a tie the requester that did not win last
// time is chosen; the history register only moves on an actual grant.
module mram_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_take,
    output logic       winner,
    output logic       last_grant
);

    // Single requester wins outright; a tie goes to the other side of last_grant
    always_comb begin
        winner = (req == 2'b11) ? ~last_grant : req[1];
    end

    // Remember who won, only on the grant edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (grant_take)
            last_grant <= winner;
    end

endmodule

// File: rtl/mram_access_arbiter.sv
// Shares one async-SRAM-style MRAM port between a write/config requester (0)
// and a readback requester (1). Sequences registered, active-low strobes
// through setup/access/hold windows and pulses ack to the granted requester.
module mram_access_arbiter
    import mram_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int T_SETUP  = 1,
    parameter int T_ACCESS = 4,
    parameter int T_HOLD   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [1:0]        be0,
    input  logic [1:0]        be1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mram_addr,
    output logic [DATA_W-1:0] mram_dq_o,
    output logic              mram_dq_oe,
    input  logic [DATA_W-1:0] mram_dq_i,
    output logic              chip_en,
    output logic              write_en,
    output logic              out_en,
    output logic              lower_byte_en,
    output logic              upper_byte_en
);

    localparam int CNT_W  = $clog2(max3(T_SETUP, T_ACCESS, T_HOLD) + 1);
    localparam int LANE_W = DATA_W / 2;
    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_ACCESS = CNT_W'(T_ACCESS - 1);
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(T_HOLD - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              cmd_we;
    logic [1:0]        cmd_be;
    logic [4:0]        strobes;
    logic              winner;
    logic              last_grant;
    logic              grant_take;
    logic              sel_we;
    logic [1:0]        sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd_masked;

    assign grant_take = (state == ST_IDLE) && (req != 2'b00);
    assign busy       = (state != ST_IDLE);
    assign {chip_en, write_en, out_en, lower_byte_en, upper_byte_en} = strobes;

    // last_grant doubles as the id of the access in flight: it only changes
    // on the grant edge, so it still names the owner when ack is raised.
    mram_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant_take (grant_take),
        .winner     (winner),
        .last_grant (last_grant)
    );

    // Select the winning requester's command and mask disabled read lanes
    always_comb begin
        sel_we    = we[winner];
        sel_be    = winner ? be1 : be0;
        sel_addr  = winner ? addr1 : addr0;
        sel_wdata = winner ? wdata1 : wdata0;
        rd_masked = '0;
        if (cmd_be[0]) rd_masked[LANE_W-1:0]      = mram_dq_i[LANE_W-1:0];
        if (cmd_be[1]) rd_masked[DATA_W-1:LANE_W] = mram_dq_i[DATA_W-1:LANE_W];
    end

    // Access sequencer: every output is set on the edge entering its state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cmd_we     <= 1'b0;
            cmd_be     <= 2'b00;
            strobes    <= STROBES_IDLE;
            mram_dq_oe <= 1'b0;
            ack        <= 2'b00;
            rdata      <= '0;
            mram_addr  <= '0;
            mram_dq_o  <= '0;
        end else begin
            ack <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (grant_take) begin
                        state      <= ST_SETUP;
                        cnt        <= LD_SETUP;
                        cmd_we     <= sel_we;
                        cmd_be     <= sel_be;
                        mram_addr  <= sel_addr;
                        if (sel_we) mram_dq_o <= sel_wdata;
                        mram_dq_oe <= sel_we;
                        strobes    <= {1'b0, 1'b1, 1'b1, ~sel_be[0], ~sel_be[1]};
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state      <= ST_ACCESS;
                        cnt        <= LD_ACCESS;
                        strobes[3] <= ~cmd_we;
                        strobes[2] <= cmd_we;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        state        <= ST_HOLD;
                        cnt          <= LD_HOLD;
                        strobes[3:2] <= 2'b11;
                        if (!cmd_we) rdata <= rd_masked;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state           <= ST_DONE;
                        strobes         <= STROBES_IDLE;
                        mram_dq_oe      <= 1'b0;
                        ack[last_grant] <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
